comb_sweep_ctrl: RTL and testbench
==================================

COMB_SWEEP_CTRL -- requirements
Module: comb_sweep_ctrl

Interface
REQ-001 Parameter SETTLE, default 1: clock cycles each vector is held on abcd before x is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
REQ-005 abort  input  1  stops a running sweep.
REQ-006 expected  input  16  golden truth table; bit i is the required x for abcd == i; sampled per vector, not latched at start.
REQ-007 x  input  1  output of the combinational unit under sweep.
REQ-008 abcd  output  4  vector driven to the unit, {a,b,c,d} with a as MSB.
REQ-009 truth  output  16  captured x per vector; bit i written when vector i is sampled.
REQ-010 mism_cnt  output  5  number of vectors where x != expected[i], 0..16.
REQ-011 busy  output  1  high in DRIVE and SAMPLE states.
REQ-012 done  output  1  single-cycle pulse at end of a complete sweep.
REQ-013 pass  output  1  registered at done: 1 iff mism_cnt == 0; held until next start.

Function
REQ-014 FSM states SHALL be IDLE, DRIVE, SAMPLE, DONE.
- IDLE: start=1 and abort=0 -> DRIVE; vec=0, settle counter=0, truth=0, mism_cnt=0, pass=0.
- DRIVE: counter increments each cycle; when counter == SETTLE-1 -> SAMPLE.
- SAMPLE: truth[vec] <= x; mism_cnt increments if x != expected[vec]; vec==15 -> DONE, else vec+1, counter=0, -> DRIVE.
- DONE: done=1, pass updated, -> IDLE on next edge.
REQ-015 abcd SHALL equal vec in DRIVE and SAMPLE and 4'd0 in IDLE and DONE.
REQ-016 Each vector SHALL occupy exactly SETTLE+1 cycles; done SHALL be high in the cycle following the edge 16*(SETTLE+1) edges after the edge accepting start (33rd cycle for SETTLE=1).
REQ-017 Vectors SHALL be applied in ascending order 0..15 with no skips or repeats; vec SHALL not wrap past 15.
REQ-018 start while busy or in DONE SHALL be ignored and SHALL not restart or extend the sweep.
REQ-019 abort=1 in DRIVE or SAMPLE SHALL force IDLE on the next edge; no truth/mism_cnt update in that SAMPLE cycle; done stays 0; truth and mism_cnt keep partial values; pass stays 0.
REQ-020 abort and start both high in IDLE: abort wins, sweep not started.
REQ-021 mism_cnt SHALL saturate at 16 by construction (at most one increment per vector); 5-bit width SHALL not overflow.
REQ-022 truth, mism_cnt and pass SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-023 rst=1 SHALL, on the next edge, force IDLE with abcd=0, truth=0, mism_cnt=0, busy=0, done=0, pass=0, vec=0, counter=0, regardless of state; rst overrides start and abort.
REQ-024 Reset mid-sweep SHALL discard the sweep with no done pulse.

Structure
REQ-025 Shared package comb_sweep_pkg SHALL hold the state encoding (2-bit), N_VECTORS=16 and VEC_W=4.
REQ-026 One sub-module, sweep_settle_timer (4-bit counter with clear/enable and terminal-count output), SHALL implement the DRIVE hold; the FSM, vector counter and capture logic stay in comb_sweep_ctrl.

Verification
REQ-027 Bench SHALL use a parity stub x = ^abcd, SETTLE=1, expected=16'h6996; start pulse -> abcd steps 0..15, done in cycle 33 after start edge, truth=16'h6996, mism_cnt=0, pass=1.
REQ-028 Same stub, expected=16'h6997 -> truth=16'h6996, mism_cnt=1, pass=0.
REQ-029 SETTLE=3, expected=16'h0000 -> each abcd value held 4 cycles, done after 64 cycles, mism_cnt=8, pass=0.
REQ-030 Abort asserted during vector 5 DRIVE -> IDLE next edge, abcd=0, no done, truth=16'h0016 (vectors 0..4 only), busy=0.
REQ-031 start re-pulsed at vectors 3 and 10, and rst pulsed during vector 7 of a second sweep -> first sweep unaffected by the start pulses; rst clears all outputs to 0 next edge, no done.
REQ-032 start and abort high together in IDLE -> busy stays 0, outputs unchanged.

Source files
------------

// File: rtl/comb_sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comb_sweep_pkg
//  Description : Shared constants for the combinational sweep controller:
//                FSM state encoding, vector count and derived widths.
//  Revision    : 1.0  initial release
// ============================================================================
package comb_sweep_pkg;

    localparam int N_VECTORS = 16;
    localparam int VEC_W     = 4;
    // Mismatch counter must hold 0..N_VECTORS inclusive.
    localparam int CNT_W     = $clog2(N_VECTORS + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRIVE  = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

endpackage : comb_sweep_pkg
`default_nettype wire

// File: rtl/comb_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : comb_sweep_ctrl_if
//  Description : Control/result bundle between a sweep requester (master)
//                and the sweep controller (slave).
//                master drives : start, abort, expected, x
//                slave drives  : abcd, truth, mism_cnt, busy, done, pass
//  Revision    : 1.0  initial release
// ============================================================================
interface comb_sweep_ctrl_if;
    import comb_sweep_pkg::*;

    logic                 start;
    logic                 abort;
    logic [N_VECTORS-1:0] expected;
    logic                 x;
    logic [VEC_W-1:0]     abcd;
    logic [N_VECTORS-1:0] truth;
    logic [CNT_W-1:0]     mism_cnt;
    logic                 busy;
    logic                 done;
    logic                 pass;

    modport master (
        output start, abort, expected, x,
        input  abcd, truth, mism_cnt, busy, done, pass
    );

    modport slave (
        input  start, abort, expected, x,
        output abcd, truth, mism_cnt, busy, done, pass
    );

endinterface : comb_sweep_ctrl_if
`default_nettype wire

// File: rtl/sweep_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_settle_timer
//  Description : 4-bit hold counter with synchronous clear and enable.
//                o_tc is high while the count equals TC_VAL.
//  Ports       : clk, rst    - clock, sync active-high reset
//                i_clr       - force count to zero (wins over i_en)
//                i_en        - increment count
//                o_tc        - terminal count reached
//  Revision    : 1.0  initial release
// ============================================================================
module sweep_settle_timer #(
    parameter logic [3:0] TC_VAL = 4'd0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_tc
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= 4'd0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule : sweep_settle_timer
`default_nettype wire

// File: rtl/comb_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : comb_sweep_ctrl
//  Description : Exhaustively sweeps a 4-input combinational unit. Each
//                vector 0..15 is held on abcd for SETTLE cycles (DRIVE), then
//                x is captured into truth and compared to expected (SAMPLE).
//                A done pulse ends a complete sweep; pass reports a clean run.
//  Ports       : clk, rst  - clock, sync active-high reset
//                bus       - comb_sweep_ctrl_if.slave
//                  start/abort/expected/x in, abcd/truth/mism_cnt/busy/done/
//                  pass out
//  Parameters  : SETTLE    - hold cycles per vector, legal 1..15
//  Revision    : 1.0  initial release
// ============================================================================
module comb_sweep_ctrl
    import comb_sweep_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    comb_sweep_ctrl_if.slave  bus
);

    localparam logic [3:0]       c_TC_VAL   = 4'(SETTLE - 1);
    localparam logic [VEC_W-1:0] c_LAST_VEC = VEC_W'(N_VECTORS - 1);

    logic [1:0]           r_state;
    logic [VEC_W-1:0]     r_vec;
    logic [N_VECTORS-1:0] r_truth;
    logic [CNT_W-1:0]     r_mism;
    logic                 r_pass;

    logic                 w_tc;
    logic                 w_miss;
    logic [CNT_W-1:0]     w_mism_nxt;
    logic                 w_busy;

    // Counter runs only in DRIVE; it is held at zero everywhere else so each
    // new vector starts its hold from a clean count.
    sweep_settle_timer #(
        .TC_VAL (c_TC_VAL)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (r_state != DRIVE),
        .i_en  (r_state == DRIVE),
        .o_tc  (w_tc)
    );

    // expected is sampled live per vector, not latched at start.
    assign w_miss     = (bus.x != bus.expected[r_vec]);
    assign w_mism_nxt = r_mism + {{(CNT_W-1){1'b0}}, w_miss};
    assign w_busy     = (r_state == DRIVE) || (r_state == SAMPLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_truth <= '0;
            r_mism  <= '0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // abort has priority over a simultaneous start.
                    if (bus.start && !bus.abort) begin
                        r_state <= DRIVE;
                        r_vec   <= '0;
                        r_truth <= '0;
                        r_mism  <= '0;
                        r_pass  <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                    end else if (w_tc) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (bus.abort) begin
                        // Partial results are kept; this vector is not captured.
                        r_state <= IDLE;
                    end else begin
                        r_truth[r_vec] <= bus.x;
                        r_mism         <= w_mism_nxt;
                        if (r_vec == c_LAST_VEC) begin
                            r_state <= DONE;
                            // Verdict includes the final vector's comparison.
                            r_pass  <= (w_mism_nxt == '0);
                        end else begin
                            r_vec   <= r_vec + 1'b1;
                            r_state <= DRIVE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.abcd     = w_busy ? r_vec : '0;
    assign bus.truth    = r_truth;
    assign bus.mism_cnt = r_mism;
    assign bus.busy     = w_busy;
    assign bus.done     = (r_state == DONE);
    assign bus.pass     = r_pass;

endmodule : comb_sweep_ctrl
`default_nettype wire

// File: tb/tb_comb_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comb_sweep_ctrl
//  Description : Directed bench for comb_sweep_ctrl with a 4-input parity
//                stub as the unit under sweep. Instance A uses SETTLE=1,
//                instance B uses SETTLE=3.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_comb_sweep_ctrl;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    comb_sweep_ctrl_if sa ();
    comb_sweep_ctrl_if sb ();

    // Parity stub: x = a^b^c^d, truth table 16'h6996.
    assign sa.x = ^sa.abcd;
    assign sb.x = ^sb.abcd;

    comb_sweep_ctrl #(.SETTLE(1)) u_dut_a (.clk(clk), .rst(rst), .bus(sa.slave));
    comb_sweep_ctrl #(.SETTLE(3)) u_dut_b (.clk(clk), .rst(rst), .bus(sb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Raise start on A for one edge; returns in the first cycle after the
    // accepting edge (cycle 1).
    task automatic pulse_start_a();
        sa.start = 1'b1;
        @(negedge clk);
        sa.start = 1'b0;
    endtask

    // Full SETTLE=1 sweep on A, cycles 1..33; optional start re-pulses in the
    // first cycle of vectors 3 and 10. Returns at cycle 34.
    task automatic full_sweep_a(input bit repulse);
        for (int c = 1; c <= 33; c++) begin
            if (c <= 32) begin
                check($sformatf("a_abcd_c%0d", c), 32'(sa.abcd), 32'((c - 1) / 2));
                check($sformatf("a_busy_c%0d", c), 32'(sa.busy), 32'd1);
                check($sformatf("a_done_c%0d", c), 32'(sa.done), 32'd0);
            end else begin
                check("a_done_pulse", 32'(sa.done), 32'd1);
                check("a_abcd_at_done", 32'(sa.abcd), 32'd0);
                check("a_busy_at_done", 32'(sa.busy), 32'd0);
            end
            sa.start = (repulse && (c == 7 || c == 21));
            @(negedge clk);
        end
        sa.start = 1'b0;
        check("a_done_one_cycle", 32'(sa.done), 32'd0);
    endtask

    task automatic check_all_zero_a(input string pfx);
        check({pfx, "_abcd"},  32'(sa.abcd),     32'd0);
        check({pfx, "_truth"}, 32'(sa.truth),    32'd0);
        check({pfx, "_mism"},  32'(sa.mism_cnt), 32'd0);
        check({pfx, "_busy"},  32'(sa.busy),     32'd0);
        check({pfx, "_done"},  32'(sa.done),     32'd0);
        check({pfx, "_pass"},  32'(sa.pass),     32'd0);
    endtask

    initial begin
        bit seen_done;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        sa.start = 1'b0; sa.abort = 1'b0; sa.expected = 16'h6996;
        sb.start = 1'b0; sb.abort = 1'b0; sb.expected = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_all_zero_a("rst_a");
        check("rst_b_busy", 32'(sb.busy), 32'd0);
        check("rst_b_abcd", 32'(sb.abcd), 32'd0);

        // Clean sweep, with ignored start re-pulses at vectors 3 and 10
        sa.expected = 16'h6996;
        pulse_start_a();
        full_sweep_a(1'b1);
        check("s1_truth", 32'(sa.truth),    32'h6996);
        check("s1_mism",  32'(sa.mism_cnt), 32'd0);
        check("s1_pass",  32'(sa.pass),     32'd1);
        check("s1_busy",  32'(sa.busy),     32'd0);
        repeat (3) @(negedge clk);
        check("s1_pass_held",  32'(sa.pass),  32'd1);
        check("s1_truth_held", 32'(sa.truth), 32'h6996);

        // One mismatch: golden bit 0 differs from parity
        sa.expected = 16'h6997;
        pulse_start_a();
        check("s2_pass_cleared",  32'(sa.pass),  32'd0);
        check("s2_truth_cleared", 32'(sa.truth), 32'd0);
        repeat (32) @(negedge clk);
        check("s2_done", 32'(sa.done), 32'd1);
        @(negedge clk);
        check("s2_truth", 32'(sa.truth),    32'h6996);
        check("s2_mism",  32'(sa.mism_cnt), 32'd1);
        check("s2_pass",  32'(sa.pass),     32'd0);

        // Abort in vector 5 DRIVE (cycle 11)
        sa.expected = 16'h6997;
        pulse_start_a();
        repeat (10) @(negedge clk);
        check("ab_abcd_pre", 32'(sa.abcd), 32'd5);
        sa.abort = 1'b1;
        @(negedge clk);
        sa.abort = 1'b0;
        check("ab_busy",  32'(sa.busy),     32'd0);
        check("ab_abcd",  32'(sa.abcd),     32'd0);
        check("ab_truth", 32'(sa.truth),    32'h0016);
        check("ab_mism",  32'(sa.mism_cnt), 32'd1);
        check("ab_pass",  32'(sa.pass),     32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen_done |= sa.done;
            @(negedge clk);
        end
        check("ab_no_done", 32'(seen_done), 32'd0);

        // start and abort together in IDLE: nothing happens
        sa.start = 1'b1; sa.abort = 1'b1;
        @(negedge clk);
        sa.start = 1'b0; sa.abort = 1'b0;
        check("sa_busy",  32'(sa.busy),     32'd0);
        check("sa_abcd",  32'(sa.abcd),     32'd0);
        check("sa_truth", 32'(sa.truth),    32'h0016);
        check("sa_mism",  32'(sa.mism_cnt), 32'd1);
        @(negedge clk);
        check("sa_busy_later", 32'(sa.busy), 32'd0);

        // Reset during vector 7 (cycle 15)
        sa.expected = 16'h0000;
        pulse_start_a();
        repeat (14) @(negedge clk);
        check("rs_abcd_pre", 32'(sa.abcd),     32'd7);
        check("rs_mism_pre", 32'(sa.mism_cnt), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero_a("rs");
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen_done |= sa.done;
            @(negedge clk);
        end
        check("rs_no_done", 32'(seen_done), 32'd0);
        check("rs_still_idle", 32'(sa.busy), 32'd0);

        // SETTLE=3 sweep on B, expected all zero
        sb.start = 1'b1;
        @(negedge clk);
        sb.start = 1'b0;
        for (int c = 1; c <= 65; c++) begin
            if (c <= 64) begin
                check($sformatf("b_abcd_c%0d", c), 32'(sb.abcd), 32'((c - 1) / 4));
                check($sformatf("b_done_c%0d", c), 32'(sb.done), 32'd0);
            end else begin
                check("b_done_pulse", 32'(sb.done), 32'd1);
            end
            @(negedge clk);
        end
        check("b_truth", 32'(sb.truth),    32'h6996);
        check("b_mism",  32'(sb.mism_cnt), 32'd8);
        check("b_pass",  32'(sb.pass),     32'd0);
        check("b_done_off", 32'(sb.done),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_comb_sweep_ctrl
`default_nettype wire
